fft_frame_sink: RTL and testbench

//  AXI-Stream sink at the FFT output port: captures one N-point complex result frame into a local buffer.

---
 rtl/fft_frame_sink.sv | 196 +++++++++++++++++++
 tb/tb_fft_frame_sink.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sink.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_sink
// Description : AXI-Stream sink for the FFT output port. Captures one
//               N-point complex frame into a local buffer, checks TLAST
//               framing, tracks the peak bin (|re|+|im|) and holds the frame
//               for random-access readout until the consumer releases it.
//               Data word: [31:16] imag, [15:0] real, signed.
// Ports       : aclk / aresetn             clock, async active-low reset
//               s_data/s_valid/s_last      stream input
//               s_ready                    stream back-pressure
//               rd_addr / rd_data          buffer readout, 1-cycle latency
//               release_frame              consumer done, re-arm capture
//               frame_done                 level: frame held in buffer
//               peak_bin / peak_mag        peak of held frame
//               err_early / err_late       1-cycle framing error pulses
//               frame_count / err_count    good frames (wrap) / errors (sat)
// Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_sink #(
    parameter int N_POINTS = 16,
    parameter int ADDR_W   = 4,
    parameter int CNT_W    = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [31:0]       s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    input  logic              release_frame,
    output logic              frame_done,
    output logic [ADDR_W-1:0] peak_bin,
    output logic [16:0]       peak_mag,
    output logic              err_early,
    output logic              err_late,
    output logic [CNT_W-1:0]  frame_count,
    output logic [7:0]        err_count
);

    localparam logic [ADDR_W-1:0] C_LAST_IDX = ADDR_W'(N_POINTS - 1);

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_armed;
    logic [ADDR_W-1:0]   r_wr_idx;
    logic [31:0]         r_buf [N_POINTS];
    logic [31:0]         r_rd_data;
    logic [16:0]         r_run_mag;
    logic [ADDR_W-1:0]   r_run_bin;
    logic [16:0]         r_peak_mag;
    logic [ADDR_W-1:0]   r_peak_bin;
    logic                r_err_early;
    logic                r_err_late;
    logic [CNT_W-1:0]    r_frame_count;
    logic [7:0]          r_err_count;

    logic                w_accept;
    logic                w_cap_beat;
    logic                w_at_last;
    logic                w_good_end;
    logic                w_early;
    logic                w_late;
    logic [15:0]         w_re;
    logic [15:0]         w_im;
    logic [16:0]         w_abs_re;
    logic [16:0]         w_abs_im;
    logic [16:0]         w_mag;
    logic                w_take;

    // s_ready stays low for the first cycle after reset release (r_armed).
    assign s_ready    = r_armed && (r_state != ST_HOLD);
    assign w_accept   = s_valid && s_ready;
    assign w_cap_beat = w_accept && (r_state == ST_CAPTURE);
    assign w_at_last  = (r_wr_idx == C_LAST_IDX);
    assign w_good_end = w_cap_beat &&  s_last &&  w_at_last;
    assign w_early    = w_cap_beat &&  s_last && !w_at_last;
    assign w_late     = w_cap_beat && !s_last &&  w_at_last;

    // Magnitude in 17 bits so |-32768| = 32768 and the sum cannot overflow.
    assign w_re     = s_data[15:0];
    assign w_im     = s_data[31:16];
    assign w_abs_re = w_re[15] ? ({1'b0, ~w_re} + 17'd1) : {1'b0, w_re};
    assign w_abs_im = w_im[15] ? ({1'b0, ~w_im} + 17'd1) : {1'b0, w_im};
    assign w_mag    = w_abs_re + w_abs_im;

    // Bin 0 always loads; strict '>' keeps the lowest bin on ties.
    assign w_take = (r_wr_idx == '0) || (w_mag > r_run_mag);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_CAPTURE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CAPTURE: begin
                if (w_good_end) begin
                    w_state_nxt = ST_HOLD;
                end else if (w_late) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_accept && s_last) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_HOLD: begin
                if (release_frame) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            default: w_state_nxt = ST_CAPTURE;
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_armed       <= 1'b0;
            r_wr_idx      <= '0;
            r_rd_data     <= '0;
            r_run_mag     <= '0;
            r_run_bin     <= '0;
            r_peak_mag    <= '0;
            r_peak_bin    <= '0;
            r_err_early   <= 1'b0;
            r_err_late    <= 1'b0;
            r_frame_count <= '0;
            r_err_count   <= '0;
        end else begin
            r_armed     <= 1'b1;
            r_rd_data   <= r_buf[rd_addr];
            r_err_early <= w_early;
            r_err_late  <= w_late;

            // Index restarts at 0 on any frame end (good, early or late) and
            // is parked at 0 outside CAPTURE.
            if (w_cap_beat) begin
                r_wr_idx <= (s_last || w_at_last) ? '0 : r_wr_idx + 1'b1;
            end else if (r_state != ST_CAPTURE) begin
                r_wr_idx <= '0;
            end

            if (w_cap_beat && w_take) begin
                r_run_mag <= w_mag;
                r_run_bin <= r_wr_idx;
            end

            // Visible peak changes only when a good frame completes; the
            // final beat itself must take part in the comparison.
            if (w_good_end) begin
                r_peak_mag    <= w_take ? w_mag : r_run_mag;
                r_peak_bin    <= w_take ? r_wr_idx : r_run_bin;
                r_frame_count <= r_frame_count + 1'b1;
            end

            if ((w_early || w_late) && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    // Buffer has no reset; contents are only meaningful while frame_done=1.
    always_ff @(posedge aclk) begin
        if (w_cap_beat) begin
            r_buf[r_wr_idx] <= s_data;
        end
    end

    assign rd_data     = r_rd_data;
    assign frame_done  = (r_state == ST_HOLD);
    assign peak_bin    = r_peak_bin;
    assign peak_mag    = r_peak_mag;
    assign err_early   = r_err_early;
    assign err_late    = r_err_late;
    assign frame_count = r_frame_count;
    assign err_count   = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_frame_sink
// Description : Directed self-checking bench for fft_frame_sink.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_frame_sink;

    localparam int N_POINTS = 16;
    localparam int ADDR_W   = 4;
    localparam int CNT_W    = 16;

    logic              aclk;
    logic              aresetn;
    logic [31:0]       s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic              release_frame;
    logic              frame_done;
    logic [ADDR_W-1:0] peak_bin;
    logic [16:0]       peak_mag;
    logic              err_early;
    logic              err_late;
    logic [CNT_W-1:0]  frame_count;
    logic [7:0]        err_count;

    int n_cmp = 0;
    int n_err = 0;

    fft_frame_sink #(
        .N_POINTS (N_POINTS),
        .ADDR_W   (ADDR_W),
        .CNT_W    (CNT_W)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .release_frame (release_frame),
        .frame_done    (frame_done),
        .peak_bin      (peak_bin),
        .peak_mag      (peak_mag),
        .err_early     (err_early),
        .err_late      (err_late),
        .frame_count   (frame_count),
        .err_count     (err_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one beat at a negedge, wait (bounded) for s_ready, let the
    // rising edge take it, return at the following negedge.
    task automatic send(input logic [31:0] d, input logic last);
        int w;
        w       = 0;
        s_data  = d;
        s_valid = 1'b1;
        s_last  = last;
        while (!s_ready && w < 8) begin
            @(negedge aclk);
            w++;
        end
        chk("beat_ready", {31'd0, s_ready}, 32'd1);
        @(posedge aclk);
        @(negedge aclk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic release_pulse();
        release_frame = 1'b1;
        @(negedge aclk);
        release_frame = 1'b0;
    endtask

    initial begin
        aresetn       = 1'b0;
        s_data        = '0;
        s_valid       = 1'b0;
        s_last        = 1'b0;
        rd_addr       = '0;
        release_frame = 1'b0;

        // ---------------- reset state
        repeat (3) @(negedge aclk);
        chk("rst_ready",   {31'd0, s_ready},     32'd0);
        chk("rst_done",    {31'd0, frame_done},  32'd0);
        chk("rst_fcnt",    {16'd0, frame_count}, 32'd0);
        chk("rst_ecnt",    {24'd0, err_count},   32'd0);
        chk("rst_pmag",    {15'd0, peak_mag},    32'd0);
        chk("rst_rdata",   rd_data,              32'd0);
        aresetn = 1'b1;
        #1;
        chk("ready_delay", {31'd0, s_ready},     32'd0);
        @(negedge aclk);
        chk("ready_armed", {31'd0, s_ready},     32'd1);

        // ---------------- 1: ramp on real part
        for (int k = 0; k < 16; k++) send({16'h0, 16'(k * 256)}, k == 15);
        chk("t1_done",  {31'd0, frame_done},  32'd1);
        chk("t1_ready", {31'd0, s_ready},     32'd0);
        chk("t1_fcnt",  {16'd0, frame_count}, 32'd1);
        chk("t1_pbin",  {28'd0, peak_bin},    32'd15);
        chk("t1_pmag",  {15'd0, peak_mag},    32'h0F00);
        rd_addr = 4'd3;
        @(negedge aclk);
        chk("t1_rd3",   rd_data,              32'h0000_0300);
        rd_addr = 4'd15;
        @(negedge aclk);
        chk("t1_rd15",  rd_data,              32'h0000_0F00);
        release_pulse();
        chk("t1_rel_ready", {31'd0, s_ready},    32'd1);
        chk("t1_rel_done",  {31'd0, frame_done}, 32'd0);

        // ---------------- 2: most negative value on both parts at bin 5
        for (int k = 0; k < 16; k++) send((k == 5) ? 32'h8000_8000 : 32'h0, k == 15);
        chk("t2_pbin", {28'd0, peak_bin},    32'd5);
        chk("t2_pmag", {15'd0, peak_mag},    32'h1_0000);
        chk("t2_fcnt", {16'd0, frame_count}, 32'd2);
        rd_addr = 4'd5;
        @(negedge aclk);
        chk("t2_rd5",  rd_data,              32'h8000_8000);
        release_pulse();

        // ---------------- 3: tie between bin 2 and bin 9 (mag 0x400)
        for (int k = 0; k < 16; k++) begin
            logic [31:0] d;
            d = 32'h0001_0001;
            if (k == 2) d = 32'h0200_0200;
            if (k == 9) d = 32'h0000_FC00;
            send(d, k == 15);
        end
        chk("t3_pbin", {28'd0, peak_bin}, 32'd2);
        chk("t3_pmag", {15'd0, peak_mag}, 32'h0400);
        rd_addr = 4'd9;
        @(negedge aclk);
        chk("t3_rd9",  rd_data,           32'h0000_FC00);
        release_pulse();

        // ---------------- 4: early TLAST on beat 10, then a good frame
        for (int k = 0; k < 11; k++) send(32'h0000_7FFF, k == 10);
        chk("t4_early",     {31'd0, err_early},  32'd1);
        chk("t4_late0",     {31'd0, err_late},   32'd0);
        chk("t4_ecnt",      {24'd0, err_count},  32'd1);
        chk("t4_done0",     {31'd0, frame_done}, 32'd0);
        @(negedge aclk);
        chk("t4_early_off", {31'd0, err_early},  32'd0);
        chk("t4_pbin_kept", {28'd0, peak_bin},   32'd2);
        chk("t4_pmag_kept", {15'd0, peak_mag},   32'h0400);
        for (int k = 0; k < 16; k++) send({16'h0, 16'(k + 1)}, k == 15);
        chk("t4_done1", {31'd0, frame_done},  32'd1);
        chk("t4_fcnt",  {16'd0, frame_count}, 32'd4);
        chk("t4_pbin",  {28'd0, peak_bin},    32'd15);
        chk("t4_pmag",  {15'd0, peak_mag},    32'd16);
        rd_addr = 4'd0;
        @(negedge aclk);
        chk("t4_rd0",   rd_data,              32'h0000_0001);
        release_pulse();

        // ---------------- 5: 20 beats, TLAST on beat 19
        for (int k = 0; k < 20; k++) begin
            send({16'h0, 16'(k)}, k == 19);
            if (k == 14) chk("t5_late_pre",  {31'd0, err_late}, 32'd0);
            if (k == 15) begin
                chk("t5_late",      {31'd0, err_late},  32'd1);
                chk("t5_early0",    {31'd0, err_early}, 32'd0);
                chk("t5_ecnt",      {24'd0, err_count}, 32'd2);
            end
            if (k == 16) chk("t5_late_off",  {31'd0, err_late}, 32'd0);
        end
        chk("t5_done0", {31'd0, frame_done}, 32'd0);
        chk("t5_ecnt2", {24'd0, err_count},  32'd2);
        for (int k = 0; k < 16; k++) send({16'h0, 16'(k + 16)}, k == 15);
        chk("t5_done1", {31'd0, frame_done},  32'd1);
        chk("t5_fcnt",  {16'd0, frame_count}, 32'd5);
        chk("t5_pmag",  {15'd0, peak_mag},    32'h1F);
        rd_addr = 4'd0;
        @(negedge aclk);
        chk("t5_rd0",   rd_data,              32'h0000_0010);

        // ---------------- 6: back-pressure in HOLD, release, async reset
        s_data  = 32'h1234_5678;
        s_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("t6_hold_ready", {31'd0, s_ready}, 32'd0);
            @(negedge aclk);
        end
        s_valid = 1'b0;
        chk("t6_fcnt_hold", {16'd0, frame_count}, 32'd5);
        chk("t6_rd0_hold",  rd_data,              32'h0000_0010);
        release_pulse();
        chk("t6_rel_ready", {31'd0, s_ready},     32'd1);
        for (int k = 0; k < 5; k++) send(32'h0000_0100, 1'b0);
        #2;
        aresetn = 1'b0;
        #1;
        chk("t6_rst_ready", {31'd0, s_ready},     32'd0);
        chk("t6_rst_done",  {31'd0, frame_done},  32'd0);
        chk("t6_rst_fcnt",  {16'd0, frame_count}, 32'd0);
        chk("t6_rst_ecnt",  {24'd0, err_count},   32'd0);
        chk("t6_rst_pbin",  {28'd0, peak_bin},    32'd0);
        chk("t6_rst_pmag",  {15'd0, peak_mag},    32'd0);
        chk("t6_rst_rdata", rd_data,              32'd0);
        chk("t6_rst_errs",  {30'd0, err_early, err_late}, 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
